// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle ARM main control FSM.
// FSM_HALT_EN swaps the one-cycle UNKNOWN state for a sticky HALT state.
package mainfsm_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
`ifdef FSM_HALT_EN
    HALT     = 4'd10
`else
    UNKNOWN  = 4'd10
`endif
  } state_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

endpackage

// File: rtl/mainfsm_if.sv
// Instruction-field inputs and datapath control outputs of the main FSM.
// The master side is the FSM; the slave side is the datapath/condition logic.
interface mainfsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       irwrite;
  logic       adrsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       aluop;
  logic       nextpc;
  logic       regw;
  logic       memw;
  logic       branch;
  logic       halted;

  modport master (
    input  op, funct,
    output irwrite, adrsrc, alusrca, alusrcb, resultsrc, aluop,
           nextpc, regw, memw, branch, halted
  );

  modport slave (
    output op, funct,
    input  irwrite, adrsrc, alusrca, alusrcb, resultsrc, aluop,
           nextpc, regw, memw, branch, halted
  );
endinterface

// File: rtl/mainfsm.sv
// Moore main control FSM for the multicycle ARM core.
// Define FSM_HALT_EN to make illegal opcodes park the core in HALT until reset.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mainfsm_if.master bus
);

  state_t state;
  state_t next;

  // Only I and L are decoded here; the rest of funct belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^bus.funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next          = FETCH;
    bus.irwrite   = 1'b0;
    bus.adrsrc    = 1'b0;
    bus.alusrca   = 1'b0;
    bus.alusrcb   = SRCB_REG;
    bus.resultsrc = RES_ALUOUT;
    bus.aluop     = 1'b0;
    bus.nextpc    = 1'b0;
    bus.regw      = 1'b0;
    bus.memw      = 1'b0;
    bus.branch    = 1'b0;
    bus.halted    = 1'b0;

    case (state)
      FETCH: begin
        next          = DECODE;
        bus.irwrite   = 1'b1;
        bus.nextpc    = 1'b1;
        bus.alusrca   = 1'b1;
        bus.alusrcb   = SRCB_FOUR;
        bus.resultsrc = RES_ALU;
      end
      DECODE: begin
        bus.alusrca   = 1'b1;
        bus.alusrcb   = SRCB_FOUR;
        bus.resultsrc = RES_ALU;
        case (bus.op)
          OP_MEM:  next = MEMADR;
          OP_DP:   next = bus.funct[5] ? EXECUTEI : EXECUTER;
          OP_B:    next = BRANCH;
`ifdef FSM_HALT_EN
          default: next = HALT;
`else
          default: next = UNKNOWN;
`endif
        endcase
      end
      MEMADR: begin
        next        = bus.funct[0] ? MEMRD : MEMWR;
        bus.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        next       = MEMWB;
        bus.adrsrc = 1'b1;
      end
      MEMWB: begin
        bus.resultsrc = RES_DATA;
        bus.regw      = 1'b1;
      end
      MEMWR: begin
        bus.adrsrc = 1'b1;
        bus.memw   = 1'b1;
      end
      EXECUTER: begin
        next      = ALUWB;
        bus.aluop = 1'b1;
      end
      EXECUTEI: begin
        next        = ALUWB;
        bus.alusrcb = SRCB_IMM;
        bus.aluop   = 1'b1;
      end
      ALUWB: begin
        bus.regw = 1'b1;
      end
      BRANCH: begin
        bus.alusrcb   = SRCB_IMM;
        bus.resultsrc = RES_ALU;
        bus.branch    = 1'b1;
      end
`ifdef FSM_HALT_EN
      HALT: begin
        next       = HALT;
        bus.halted = 1'b1;
      end
`else
      UNKNOWN: next = FETCH;
`endif
      default: next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Directed self-checking bench for mainfsm; outputs are packed into one vector
// and compared against hand-written per-state constants every cycle.
module tb_mainfsm;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mainfsm_if bus ();

  mainfsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {irwrite, adrsrc, alusrca, alusrcb[1:0], resultsrc[1:0], aluop, nextpc, regw, memw, branch, halted}
  logic [12:0] obs;
  assign obs = {bus.irwrite, bus.adrsrc, bus.alusrca, bus.alusrcb, bus.resultsrc,
                bus.aluop, bus.nextpc, bus.regw, bus.memw, bus.branch, bus.halted};

  localparam logic [12:0] E_FETCH    = 13'b1_0_1_10_10_0_1_0_0_0_0;
  localparam logic [12:0] E_DECODE   = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] E_MEMADR   = 13'b0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [12:0] E_MEMRD    = 13'b0_1_0_00_00_0_0_0_0_0_0;
  localparam logic [12:0] E_MEMWB    = 13'b0_0_0_00_01_0_0_1_0_0_0;
  localparam logic [12:0] E_MEMWR    = 13'b0_1_0_00_00_0_0_0_1_0_0;
  localparam logic [12:0] E_EXECUTER = 13'b0_0_0_00_00_1_0_0_0_0_0;
  localparam logic [12:0] E_EXECUTEI = 13'b0_0_0_01_00_1_0_0_0_0_0;
  localparam logic [12:0] E_ALUWB    = 13'b0_0_0_00_00_0_0_1_0_0_0;
  localparam logic [12:0] E_BRANCH   = 13'b0_0_0_01_10_0_0_0_0_1_0;
  localparam logic [12:0] E_UNKNOWN  = 13'b0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [12:0] E_HALT     = 13'b0_0_0_00_00_0_0_0_0_0_1;

  task automatic checkOutput(input string tag, input logic [12:0] observed,
                             input logic [12:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct);
    bus.op    = op;
    bus.funct = funct;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic stepAndCheck(input string tag, input logic [12:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, obs, expected);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 6'b000000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", obs, E_FETCH);
    reset = 1'b0;

    // LDR; inputs change after MEMADR to show they are ignored afterwards
    applyStimulus(2'b01, 6'b011001);
    stepAndCheck("ldr_decode", E_DECODE);
    stepAndCheck("ldr_memadr", E_MEMADR);
    stepAndCheck("ldr_memrd", E_MEMRD);
    applyStimulus(2'b11, 6'b000000);
    stepAndCheck("ldr_memwb", E_MEMWB);
    stepAndCheck("ldr_fetch", E_FETCH);

    // STR
    applyStimulus(2'b01, 6'b011000);
    stepAndCheck("str_decode", E_DECODE);
    stepAndCheck("str_memadr", E_MEMADR);
    stepAndCheck("str_memwr", E_MEMWR);
    stepAndCheck("str_fetch", E_FETCH);

    // ADD immediate then ADD register
    applyStimulus(2'b00, 6'b101000);
    stepAndCheck("addi_decode", E_DECODE);
    stepAndCheck("addi_execi", E_EXECUTEI);
    stepAndCheck("addi_aluwb", E_ALUWB);
    stepAndCheck("addi_fetch", E_FETCH);
    applyStimulus(2'b00, 6'b001000);
    stepAndCheck("addr_decode", E_DECODE);
    stepAndCheck("addr_execr", E_EXECUTER);
    stepAndCheck("addr_aluwb", E_ALUWB);
    stepAndCheck("addr_fetch", E_FETCH);

    // Branch
    applyStimulus(2'b10, 6'b000000);
    stepAndCheck("b_decode", E_DECODE);
    stepAndCheck("b_branch", E_BRANCH);
    stepAndCheck("b_fetch", E_FETCH);

    // Reset held 3 cycles mid-MEMRD aborts the load without a regw pulse
    applyStimulus(2'b01, 6'b011001);
    stepAndCheck("rst_decode", E_DECODE);
    stepAndCheck("rst_memadr", E_MEMADR);
    stepAndCheck("rst_memrd", E_MEMRD);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) stepAndCheck($sformatf("rst_hold%0d", i), E_FETCH);
    reset = 1'b0;
    applyStimulus(2'b10, 6'b000000);
    stepAndCheck("rst_post_decode", E_DECODE);
    stepAndCheck("rst_post_branch", E_BRANCH);
    stepAndCheck("rst_post_fetch", E_FETCH);

    // Illegal opcode
    applyStimulus(2'b11, 6'b000000);
    stepAndCheck("ill_decode", E_DECODE);
`ifdef FSM_HALT_EN
    applyStimulus(2'b00, 6'b000000);
    for (int i = 0; i < 20; i++) stepAndCheck($sformatf("ill_halt%0d", i), E_HALT);
    reset = 1'b1;
    stepAndCheck("ill_reset", E_FETCH);
    reset = 1'b0;
    stepAndCheck("ill_post_decode", E_DECODE);
`else
    stepAndCheck("ill_unknown", E_UNKNOWN);
    stepAndCheck("ill_fetch", E_FETCH);
    applyStimulus(2'b00, 6'b100000);
    stepAndCheck("ill_post_decode", E_DECODE);
    stepAndCheck("ill_post_execi", E_EXECUTEI);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
